// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        LOAD_A,
        LOAD_B,
        WAIT,
        RESP
    } state_t;

    // Bit positions inside the 4-bit flag bus {negative, zero, carry, overflow}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: the requester not granted last wins a tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic last_grant;

    // Reset as if r1 was granted last so r0 holds priority first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (update && (grant != 2'b00)) begin
            last_grant <= grant[1];
        end
    end

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one multi-cycle ALU between two requesters, one operation in flight.
// Define ALU_ARB_TIMEOUT_EN to abort operations the ALU never finishes.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_valid,
    input  logic        r1_valid,
    output logic        r0_ready,
    output logic        r1_ready,
    input  logic [3:0]  r0_op,
    input  logic [3:0]  r1_op,
    input  logic [15:0] r0_a,
    input  logic [15:0] r0_b,
    input  logic [15:0] r1_a,
    input  logic [15:0] r1_b,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [15:0] rsp_data,
    output logic [3:0]  rsp_flags,
    output logic        rsp_err,
    output logic        alu_start,
    output logic [3:0]  alu_s,
    output logic [15:0] alu_inbus,
    input  logic [15:0] alu_outbus,
    input  logic [3:0]  alu_flags,
    input  logic        alu_finish,
    output logic        alu_rst_b
);

    state_t      state, next_state;
    logic [1:0]  grant;
    logic        accept;
    logic        timeout_hit;
    logic        owner_q;
    logic [3:0]  op_q;
    logic [15:0] a_q, b_q;
    logic        rst_hold_q;

    assign accept   = (state == IDLE) && !rst && (r0_valid || r1_valid);
    assign r0_ready = accept && grant[0];
    assign r1_ready = accept && grant[1];
    assign alu_s    = op_q;

    rr_arb2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    ({r1_valid, r0_valid}),
        .update (accept),
        .grant  (grant)
    );

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst || (state != WAIT)) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign timeout_hit = (state == WAIT) && !alu_finish &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_err <= 1'b0;
        end else if ((state == WAIT) && alu_finish) begin
            rsp_err <= 1'b0;
        end else if (timeout_hit) begin
            rsp_err <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
    assign rsp_err            = 1'b0;
`endif

    // The ALU reset is held through reset plus one cycle, and pulsed on a timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_hold_q <= 1'b0;
        end else begin
            rst_hold_q <= !timeout_hit;
        end
    end

    assign alu_rst_b = !rst && rst_hold_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q   <= 1'b0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rsp_data  <= '0;
            rsp_flags <= '0;
        end else begin
            if (accept) begin
                owner_q <= grant[1];
                op_q    <= grant[1] ? r1_op : r0_op;
                a_q     <= grant[1] ? r1_a : r0_a;
                b_q     <= grant[1] ? r1_b : r0_b;
            end
            if ((state == WAIT) && alu_finish) begin
                rsp_data          <= alu_outbus;
                rsp_flags[FLAG_N] <= alu_flags[FLAG_N];
                rsp_flags[FLAG_Z] <= alu_flags[FLAG_Z];
                rsp_flags[FLAG_C] <= alu_flags[FLAG_C];
                rsp_flags[FLAG_V] <= alu_flags[FLAG_V];
            end else if (timeout_hit) begin
                rsp_data  <= '0;
                rsp_flags <= '0;
            end
        end
    end

    always_comb begin
        next_state = state;
        alu_start  = 1'b0;
        alu_inbus  = '0;
        rsp_valid  = 2'b00;
        case (state)
            IDLE: begin
                if (r0_valid || r1_valid) next_state = START;
            end
            START: begin
                alu_start  = 1'b1;
                next_state = LOAD_A;
            end
            LOAD_A: begin
                alu_inbus  = a_q;
                next_state = LOAD_B;
            end
            LOAD_B: begin
                alu_inbus  = b_q;
                next_state = WAIT;
            end
            WAIT: begin
                if (alu_finish || timeout_hit) next_state = RESP;
            end
            RESP: begin
                rsp_valid = owner_q ? 2'b10 : 2'b01;
                if (rsp_ready[owner_q]) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU answering the command side.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_valid, r1_valid;
    logic        r0_ready, r1_ready;
    logic [3:0]  r0_op, r1_op;
    logic [15:0] r0_a, r0_b, r1_a, r1_b;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_flags;
    logic        rsp_err;
    logic        alu_start;
    logic [3:0]  alu_s;
    logic [15:0] alu_inbus;
    logic [15:0] alu_outbus;
    logic [3:0]  alu_flags;
    logic        alu_finish;
    logic        alu_rst_b;

    typedef struct {
        logic [1:0]  owner;
        logic [15:0] data;
        logic [3:0]  flags;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   rr_next = 1'b0;
    int   alu_delay = 2;
    bit   alu_hang = 1'b0;
    bit   finish_extra = 1'b0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .r0_valid   (r0_valid),
        .r1_valid   (r1_valid),
        .r0_ready   (r0_ready),
        .r1_ready   (r1_ready),
        .r0_op      (r0_op),
        .r1_op      (r1_op),
        .r0_a       (r0_a),
        .r0_b       (r0_b),
        .r1_a       (r1_a),
        .r1_b       (r1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_flags  (rsp_flags),
        .rsp_err    (rsp_err),
        .alu_start  (alu_start),
        .alu_s      (alu_s),
        .alu_inbus  (alu_inbus),
        .alu_outbus (alu_outbus),
        .alu_flags  (alu_flags),
        .alu_finish (alu_finish),
        .alu_rst_b  (alu_rst_b)
    );

    // Returns {result, N, Z, C, V}: op 0 add, op 1 subtract, anything else xor.
    function automatic logic [19:0] alu_calc(input logic [3:0] op, input logic [15:0] a,
                                             input logic [15:0] b);
        logic [16:0] wide;
        logic        v;
        wide = '0;
        v    = 1'b0;
        case (op)
            4'd0: begin
                wide = {1'b0, a} + {1'b0, b};
                v    = (a[15] == b[15]) && (wide[15] != a[15]);
            end
            4'd1: begin
                wide = {1'b0, a} - {1'b0, b};
                v    = (a[15] != b[15]) && (wide[15] != a[15]);
            end
            default: wide = {1'b0, a ^ b};
        endcase
        return {wide[15:0], wide[15], (wide[15:0] == 16'h0), wide[16], v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0]  m_op;
        logic [15:0] m_a, m_b;
        logic [19:0] res;
        alu_finish = 1'b0;
        alu_outbus = '0;
        alu_flags  = '0;
        forever begin
            tick();
            if (alu_start === 1'b1) begin
                m_op = alu_s;
                tick();
                m_a = alu_inbus;
                tick();
                m_b = alu_inbus;
                tick();
                if (!alu_hang) begin
                    repeat (alu_delay) tick();
                    res        = alu_calc(m_op, m_a, m_b);
                    alu_finish = 1'b1;
                    alu_outbus = res[19:4];
                    alu_flags  = res[3:0];
                    tick();
                    // A lingering finish lands in RESP and must not disturb the response.
                    if (finish_extra) begin
                        alu_outbus = ~res[19:4];
                        alu_flags  = ~res[3:0];
                        tick();
                    end
                    alu_finish = 1'b0;
                    alu_outbus = '0;
                    alu_flags  = '0;
                end
            end
        end
    end

    task automatic do_reset();
        rst       = 1'b1;
        r0_valid  = 1'b0;
        r1_valid  = 1'b0;
        rsp_ready = 2'b00;
        tick();
        tick();
        rst     = 1'b0;
        rr_next = 1'b0;
        sb_q.delete();
        tick();
        tick();
    endtask

    task automatic issue(input bit v0, input bit v1,
                         input logic [3:0] op0, input logic [15:0] a0, input logic [15:0] b0,
                         input logic [3:0] op1, input logic [15:0] a1, input logic [15:0] b1,
                         input bit expect_rsp);
        int          w;
        logic [19:0] res;
        logic [1:0]  exp_grant;
        logic [3:0]  exp_op;
        w         = (v0 && v1) ? int'(rr_next) : (v1 ? 1 : 0);
        rr_next   = (w == 0);
        exp_grant = (w == 1) ? 2'b10 : 2'b01;
        exp_op    = (w == 1) ? op1 : op0;
        res       = (w == 1) ? alu_calc(op1, a1, b1) : alu_calc(op0, a0, b0);
        r0_valid  = v0;
        r1_valid  = v1;
        r0_op = op0; r0_a = a0; r0_b = b0;
        r1_op = op1; r1_a = a1; r1_b = b1;
        #1;
        checks++;
        if ({r1_ready, r0_ready} !== exp_grant) begin
            errors++;
            $display("[TB] FAIL grant: got %b expected %b", {r1_ready, r0_ready}, exp_grant);
        end
        if (expect_rsp) sb_q.push_back('{exp_grant, res[19:4], res[3:0], 1'b0});
        tick();
        checks++;
        if (alu_start !== 1'b1 || alu_s !== exp_op) begin
            errors++;
            $display("[TB] FAIL issue_latency: start=%b s=%h expected start=1 s=%h",
                     alu_start, alu_s, exp_op);
        end
        checks++;
        if ({r1_ready, r0_ready} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL ready_outside_idle: got %b expected 00", {r1_ready, r0_ready});
        end
        if (w == 1) r1_valid = 1'b0;
        else        r0_valid = 1'b0;
    endtask

    task automatic collect(input int hold);
        int   n;
        exp_t e;
        n = 0;
        while (rsp_valid === 2'b00 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (rsp_valid === 2'b00) begin
            errors++;
            $display("[TB] FAIL rsp_arrival: got no response after %0d cycles expected one", n);
            return;
        end
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL rsp_expected: got rsp_valid=%b expected no response", rsp_valid);
            return;
        end
        e = sb_q.pop_front();
        checks++;
        if (rsp_valid !== e.owner) begin
            errors++;
            $display("[TB] FAIL rsp_owner: got %b expected %b", rsp_valid, e.owner);
        end
        checks++;
        if (rsp_data !== e.data) begin
            errors++;
            $display("[TB] FAIL rsp_data: got %h expected %h", rsp_data, e.data);
        end
        checks++;
        if (rsp_flags !== e.flags) begin
            errors++;
            $display("[TB] FAIL rsp_flags: got %b expected %b", rsp_flags, e.flags);
        end
        checks++;
        if (rsp_err !== e.err) begin
            errors++;
            $display("[TB] FAIL rsp_err: got %b expected %b", rsp_err, e.err);
        end
        for (int i = 0; i < hold; i++) begin
            rsp_ready = ~e.owner;
            tick();
            checks++;
            if (rsp_valid !== e.owner || rsp_data !== e.data || rsp_flags !== e.flags) begin
                errors++;
                $display("[TB] FAIL hold_stable: got valid=%b data=%h flags=%b expected %b %h %b",
                         rsp_valid, rsp_data, rsp_flags, e.owner, e.data, e.flags);
            end
            checks++;
            if ({r1_ready, r0_ready, alu_start} !== 3'b000) begin
                errors++;
                $display("[TB] FAIL no_grant_in_resp: got ready=%b start=%b expected 00 0",
                         {r1_ready, r0_ready}, alu_start);
            end
        end
        rsp_ready = e.owner;
        tick();
        rsp_ready = 2'b00;
        checks++;
        if (rsp_valid !== 2'b00) begin
            errors++;
            $display("[TB] FAIL rsp_release: got %b expected 00", rsp_valid);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        r0_valid  = 1'b1;
        r1_valid  = 1'b1;
        rsp_ready = 2'b00;
        tick();
        tick();
        checks++;
        if ({r1_ready, r0_ready, rsp_valid, alu_start, rsp_err} !== 6'b0 ||
            rsp_data !== 16'h0 || rsp_flags !== 4'h0 || alu_s !== 4'h0 || alu_inbus !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got ready=%b valid=%b data=%h flags=%b s=%h inbus=%h expected all zero",
                     {r1_ready, r0_ready}, rsp_valid, rsp_data, rsp_flags, alu_s, alu_inbus);
        end
        checks++;
        if (alu_rst_b !== 1'b0) begin
            errors++;
            $display("[TB] FAIL alu_rst_b_in_reset: got %b expected 0", alu_rst_b);
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        rst      = 1'b0;
        rr_next  = 1'b0;
        #1;
        checks++;
        if (alu_rst_b !== 1'b0) begin
            errors++;
            $display("[TB] FAIL alu_rst_b_after_reset: got %b expected 0", alu_rst_b);
        end
        tick();
        checks++;
        if (alu_rst_b !== 1'b1) begin
            errors++;
            $display("[TB] FAIL alu_rst_b_release: got %b expected 1", alu_rst_b);
        end
    endtask

    task automatic test_fairness();
        alu_delay = 1;
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 1'b1, 4'(i % 3), 16'($urandom), 16'($urandom),
                  4'((i + 1) % 3), 16'($urandom), 16'($urandom), 1'b1);
            collect(0);
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;
    endtask

    task automatic test_basic();
        alu_delay = 2;
        issue(1'b1, 1'b0, 4'd0, 16'h0005, 16'h0003, 4'd0, 16'h0, 16'h0, 1'b1);
        tick();
        checks++;
        if (alu_inbus !== 16'h0005 || alu_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_a: got inbus=%h start=%b expected 0005 0", alu_inbus, alu_start);
        end
        tick();
        checks++;
        if (alu_inbus !== 16'h0003) begin
            errors++;
            $display("[TB] FAIL load_b: got %h expected 0003", alu_inbus);
        end
        collect(0);
    endtask

    task automatic test_backpressure();
        finish_extra = 1'b1;
        alu_delay    = 0;
        issue(1'b1, 1'b0, 4'd0, 16'h7fff, 16'h0001, 4'd0, 16'h0, 16'h0, 1'b1);
        r1_valid = 1'b1;
        r1_op    = 4'd2;
        r1_a     = 16'h00ff;
        r1_b     = 16'h0f0f;
        collect(5);
        finish_extra = 1'b0;
        issue(1'b0, 1'b1, 4'd0, 16'h0, 16'h0, 4'd2, 16'h00ff, 16'h0f0f, 1'b1);
        collect(0);
    endtask

    task automatic test_lone_r1();
        logic [3:0]  ops[3];
        logic [15:0] as[3];
        logic [15:0] bs[3];
        ops = '{4'd1, 4'd1, 4'd2};
        as  = '{16'h1234, 16'h0001, 16'h00ff};
        bs  = '{16'h1234, 16'h0002, 16'hff00};
        for (int i = 0; i < 3; i++) begin
            alu_delay = i * 2;
            issue(1'b0, 1'b1, 4'd0, 16'h0, 16'h0, ops[i], as[i], bs[i], 1'b1);
            collect(0);
        end
    endtask

    task automatic test_reset_during_wait();
        alu_hang = 1'b1;
        issue(1'b0, 1'b1, 4'd0, 16'h0, 16'h0, 4'd0, 16'h1111, 16'h2222, 1'b0);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({r1_ready, r0_ready, rsp_valid, alu_start, rsp_err, alu_rst_b} !== 7'b0 ||
            rsp_data !== 16'h0 || rsp_flags !== 4'h0 || alu_s !== 4'h0 || alu_inbus !== 16'h0) begin
            errors++;
            $display("[TB] FAIL mid_op_reset: got valid=%b data=%h flags=%b s=%h inbus=%h rst_b=%b expected all zero",
                     rsp_valid, rsp_data, rsp_flags, alu_s, alu_inbus, alu_rst_b);
        end
        rst      = 1'b0;
        rr_next  = 1'b0;
        alu_hang = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (rsp_valid !== 2'b00) begin
                errors++;
                $display("[TB] FAIL no_rsp_after_reset: got %b expected 00", rsp_valid);
            end
        end
        alu_delay = 1;
        issue(1'b1, 1'b1, 4'd1, 16'h0010, 16'h0004, 4'd0, 16'h0001, 16'h0001, 1'b1);
        r1_valid = 1'b0;
        collect(0);
    endtask

    task automatic test_timeout();
`ifdef ALU_ARB_TIMEOUT_EN
        int cnt;
        bit rst_b_ok;
        alu_hang = 1'b1;
        issue(1'b1, 1'b0, 4'd0, 16'h4444, 16'h1111, 4'd0, 16'h0, 16'h0, 1'b0);
        sb_q.push_back('{2'b01, 16'h0000, 4'h0, 1'b1});
        tick();
        tick();
        tick();
        cnt      = 1;
        rst_b_ok = 1'b1;
        while (rsp_valid === 2'b00 && cnt < 200) begin
            if (alu_rst_b !== 1'b1) rst_b_ok = 1'b0;
            tick();
            if (rsp_valid === 2'b00) cnt++;
        end
        checks++;
        if (cnt != 64) begin
            errors++;
            $display("[TB] FAIL timeout_cycles: got %0d WAIT cycles expected 64", cnt);
        end
        checks++;
        if (!rst_b_ok || alu_rst_b !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_rst_pulse: got held_high=%b now=%b expected 1 0", rst_b_ok, alu_rst_b);
        end
        collect(0);
        checks++;
        if (alu_rst_b !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_rst_end: got %b expected 1", alu_rst_b);
        end
        alu_hang = 1'b0;
`else
        bit quiet;
        alu_hang = 1'b1;
        quiet    = 1'b1;
        issue(1'b1, 1'b0, 4'd0, 16'h4444, 16'h1111, 4'd0, 16'h0, 16'h0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            tick();
            if (rsp_valid !== 2'b00 || rsp_err !== 1'b0 || alu_rst_b !== 1'b1) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("[TB] FAIL wait_forever: got a response, error or ALU reset expected none");
        end
        do_reset();
        alu_hang = 1'b0;
`endif
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        r0_valid  = 1'b0;
        r1_valid  = 1'b0;
        r0_op = '0; r0_a = '0; r0_b = '0;
        r1_op = '0; r1_a = '0; r1_b = '0;
        rsp_ready = 2'b00;
        test_reset();
        test_fairness();
        test_basic();
        test_backpressure();
        test_lone_r1();
        test_reset_during_wait();
        test_timeout();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
